// File: rtl/commit_stage.sv
// Write-back stage: registers the two-lane commit bundle and drives the RF write ports once per pair.
// Latency: 1 cycle from capture edge to rf_*/fwd_*; retire_cnt is updated one edge later.
// Backpressure: stall holds the pair (in_ready low), with writes suppressed after its first cycle; flush wins over stall.
module commit_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [1:0][DATA_W+ADDR_W:0]        cmt_require,
    input  logic [1:0]                         in_valid,
    input  logic                               stall,
    input  logic                               flush,
    output logic                               in_ready,
    output logic [1:0]                         rf_we,
    output logic [1:0][ADDR_W-1:0]             rf_waddr,
    output logic [1:0][DATA_W-1:0]             rf_wdata,
    output logic [1:0]                         fwd_valid,
    output logic [1:0][ADDR_W-1:0]             fwd_addr,
    output logic [1:0][DATA_W-1:0]             fwd_data,
    output logic [CNT_W-1:0]                   retire_cnt
);

    logic [1:0]              v;
    logic [1:0]              need;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][DATA_W-1:0]  res;
    logic                    done;
    logic [1:0]              we_raw;

    // Each lane is packed as {result, write_reg_need, write_reg_addr}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= '0;
            need <= '0;
            addr <= '0;
            res  <= '0;
            done <= 1'b0;
        end else if (flush) begin
            v    <= '0;
            done <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < 2; i++) begin
                res[i]  <= cmt_require[i][DATA_W+ADDR_W:ADDR_W+1];
                need[i] <= cmt_require[i][ADDR_W];
                addr[i] <= cmt_require[i][ADDR_W-1:0];
            end
            v    <= in_valid;
            done <= 1'b0;
        end else if (|v) begin
            // Held pair has had its one write/retire opportunity.
            done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (!done) begin
            retire_cnt <= retire_cnt + CNT_W'(v[0]) + CNT_W'(v[1]);
        end
    end

    always_comb begin
        fwd_valid = '0;
        we_raw    = '0;
        rf_we     = '0;
        for (int i = 0; i < 2; i++) begin
            fwd_valid[i] = v[i] & need[i] & (addr[i] != '0);
            we_raw[i]    = fwd_valid[i] & ~done;
        end
        // Same-cycle WAW: the younger lane 1 owns the register.
        rf_we[1] = we_raw[1];
        rf_we[0] = we_raw[0] & ~(we_raw[1] & (addr[0] == addr[1]));
    end

    assign in_ready = ~stall;
    assign rf_waddr = addr;
    assign rf_wdata = res;
    assign fwd_addr = addr;
    assign fwd_data = res;

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios plus randomized traffic against a pair-level model.
module tb_commit_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    logic                     clk;
    logic                     rst_n;
    logic [1:0][DW+AW:0]      cmt_require;
    logic [1:0]               in_valid;
    logic                     stall;
    logic                     flush;
    logic                     in_ready;
    logic [1:0]               rf_we;
    logic [1:0][AW-1:0]       rf_waddr;
    logic [1:0][DW-1:0]       rf_wdata;
    logic [1:0]               fwd_valid;
    logic [1:0][AW-1:0]       fwd_addr;
    logic [1:0][DW-1:0]       fwd_data;
    logic [CW-1:0]            retire_cnt;

    int total = 0;
    int bad   = 0;

    // Model of the pair currently sitting in the stage.
    logic [1:0]               m_v;
    logic [1:0]               m_need;
    logic [1:0][AW-1:0]       m_addr;
    logic [1:0][DW-1:0]       m_res;
    bit                       m_retired;
    logic [CW-1:0]            m_cnt;

    commit_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmt_require (cmt_require),
        .in_valid    (in_valid),
        .stall       (stall),
        .flush       (flush),
        .in_ready    (in_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .retire_cnt  (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_v = '0; m_need = '0; m_addr = '0; m_res = '0;
        m_retired = 1'b0; m_cnt = '0;
    endtask

    task automatic set_lane(input int i, input bit vld, input bit nd, input logic [AW-1:0] a, input logic [DW-1:0] r);
        cmt_require[i] = {r, nd, a};
        in_valid[i]    = vld;
    endtask

    task automatic idle_inputs();
        set_lane(0, 1'b0, 1'b0, '0, '0);
        set_lane(1, 1'b0, 1'b0, '0, '0);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    // One rising edge; the model sees the inputs that were present at that edge.
    task automatic clock_edge();
        @(posedge clk);
        if (!m_retired) m_cnt = m_cnt + CW'($countones(m_v));
        if (flush) begin
            m_v = '0;
            m_retired = 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < 2; i++) begin
                m_v[i]    = in_valid[i];
                m_need[i] = cmt_require[i][AW];
                m_addr[i] = cmt_require[i][AW-1:0];
                m_res[i]  = cmt_require[i][DW+AW:AW+1];
            end
            m_retired = 1'b0;
        end else begin
            m_retired = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (rf_we !== 2'b00 || fwd_valid !== 2'b00) begin bad++; $display("FAIL reset_en: we=%b fwd=%b want 00/00", rf_we, fwd_valid); end
        total++; if (retire_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
        total++; if (rf_waddr !== '0 || rf_wdata !== '0 || fwd_addr !== '0 || fwd_data !== '0) begin bad++; $display("FAIL reset_dat: waddr=%h wdata=%h want 0", rf_waddr, rf_wdata); end
        rst_n = 1'b1;
        set_lane(0, 1'b1, 1'b1, 5'd9,  32'h99);
        set_lane(1, 1'b1, 1'b1, 5'd10, 32'h1010);
        clock_edge();
        stall = 1'b1;
        clock_edge();
        // Asynchronous reset in the middle of a stalled cycle.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (rf_we !== 2'b00 || fwd_valid !== 2'b00) begin bad++; $display("FAIL async_reset_en: we=%b fwd=%b want 00/00", rf_we, fwd_valid); end
        total++; if (retire_cnt !== '0) begin bad++; $display("FAIL async_reset_cnt: got %0d want 0", retire_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        clock_edge();
        total++; if (retire_cnt !== '0) begin bad++; $display("FAIL reset_pair_lost: cnt=%0d want 0", retire_cnt); end
    endtask

    task automatic test_dual_write();
        logic [CW-1:0] base;
        base = retire_cnt;
        set_lane(0, 1'b1, 1'b1, 5'd3, 32'hA);
        set_lane(1, 1'b1, 1'b1, 5'd7, 32'hB);
        clock_edge();
        idle_inputs();
        @(negedge clk);
        total++; if (rf_we !== 2'b11) begin bad++; $display("FAIL dual_we: got %b want 11", rf_we); end
        total++; if (rf_waddr[1] !== 5'd7 || rf_waddr[0] !== 5'd3) begin bad++; $display("FAIL dual_waddr: got %0d/%0d want 7/3", rf_waddr[1], rf_waddr[0]); end
        total++; if (rf_wdata[1] !== 32'hB || rf_wdata[0] !== 32'hA) begin bad++; $display("FAIL dual_wdata: got %h/%h want b/a", rf_wdata[1], rf_wdata[0]); end
        total++; if (fwd_valid !== 2'b11) begin bad++; $display("FAIL dual_fwd: got %b want 11", fwd_valid); end
        clock_edge();
        total++; if (retire_cnt !== base + 2) begin bad++; $display("FAIL dual_cnt: got %0d want %0d", retire_cnt, base + 2); end
    endtask

    task automatic test_waw();
        logic [CW-1:0] base;
        base = retire_cnt;
        set_lane(0, 1'b1, 1'b1, 5'd5, 32'h11);
        set_lane(1, 1'b1, 1'b1, 5'd5, 32'h22);
        clock_edge();
        idle_inputs();
        @(negedge clk);
        total++; if (rf_we !== 2'b10) begin bad++; $display("FAIL waw_we: got %b want 10", rf_we); end
        total++; if (rf_wdata[1] !== 32'h22) begin bad++; $display("FAIL waw_wdata: got %h want 22", rf_wdata[1]); end
        clock_edge();
        total++; if (retire_cnt !== base + 2) begin bad++; $display("FAIL waw_cnt: got %0d want %0d", retire_cnt, base + 2); end
    endtask

    task automatic test_zero_nowrite();
        logic [CW-1:0] base;
        base = retire_cnt;
        set_lane(0, 1'b1, 1'b1, 5'd0, 32'h33);
        set_lane(1, 1'b1, 1'b0, 5'd4, 32'h44);
        clock_edge();
        idle_inputs();
        @(negedge clk);
        total++; if (rf_we !== 2'b00 || fwd_valid !== 2'b00) begin bad++; $display("FAIL zero_en: we=%b fwd=%b want 00/00", rf_we, fwd_valid); end
        clock_edge();
        total++; if (retire_cnt !== base + 2) begin bad++; $display("FAIL zero_cnt: got %0d want %0d", retire_cnt, base + 2); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] base;
        base = retire_cnt;
        set_lane(0, 1'b1, 1'b1, 5'd12, 32'hC0DE);
        set_lane(1, 1'b0, 1'b1, 5'd13, 32'h0);
        clock_edge();
        stall = 1'b1;
        set_lane(0, 1'b1, 1'b1, 5'd20, 32'hDEAD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rf_we !== (c == 0 ? 2'b01 : 2'b00)) begin bad++; $display("FAIL stall_we[%0d]: got %b want %b", c, rf_we, (c == 0 ? 2'b01 : 2'b00)); end
            total++; if (fwd_valid !== 2'b01 || fwd_addr[0] !== 5'd12) begin bad++; $display("FAIL stall_fwd[%0d]: got %b/%0d want 01/12", c, fwd_valid, fwd_addr[0]); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", c, in_ready); end
            clock_edge();
        end
        idle_inputs();
        clock_edge();
        total++; if (retire_cnt !== base + 1) begin bad++; $display("FAIL stall_cnt: got %0d want %0d", retire_cnt, base + 1); end
    endtask

    task automatic test_flush_stall();
        logic [CW-1:0] base;
        base = retire_cnt;
        set_lane(0, 1'b1, 1'b1, 5'd1, 32'h1);
        set_lane(1, 1'b1, 1'b1, 5'd2, 32'h2);
        clock_edge();
        stall = 1'b1;
        clock_edge();
        flush = 1'b1;
        set_lane(0, 1'b1, 1'b1, 5'd8, 32'h8);
        set_lane(1, 1'b1, 1'b1, 5'd9, 32'h9);
        clock_edge();
        idle_inputs();
        @(negedge clk);
        total++; if (rf_we !== 2'b00 || fwd_valid !== 2'b00) begin bad++; $display("FAIL flush_en: we=%b fwd=%b want 00/00", rf_we, fwd_valid); end
        clock_edge();
        total++; if (retire_cnt !== base + 2) begin bad++; $display("FAIL flush_cnt: got %0d want %0d", retire_cnt, base + 2); end
    endtask

    task automatic test_random();
        logic [1:0] e_fv;
        logic [1:0] e_we;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++)
                set_lane(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), DW'($urandom));
            stall = $urandom_range(0, 9) < 3;
            flush = $urandom_range(0, 9) == 0;
            @(negedge clk);
            for (int i = 0; i < 2; i++) e_fv[i] = m_v[i] && m_need[i] && (m_addr[i] != 0);
            e_we = m_retired ? 2'b00 : e_fv;
            if (e_we == 2'b11 && m_addr[0] == m_addr[1]) e_we[0] = 1'b0;
            total++; if (rf_we !== e_we) begin bad++; $display("FAIL rnd_we[%0d]: got %b want %b", c, rf_we, e_we); end
            total++; if (fwd_valid !== e_fv) begin bad++; $display("FAIL rnd_fwd[%0d]: got %b want %b", c, fwd_valid, e_fv); end
            total++; if (rf_waddr !== m_addr || fwd_addr !== m_addr) begin bad++; $display("FAIL rnd_addr[%0d]: got %h/%h want %h", c, rf_waddr, fwd_addr, m_addr); end
            total++; if (rf_wdata !== m_res || fwd_data !== m_res) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, rf_wdata, m_res); end
            total++; if (retire_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, retire_cnt, m_cnt); end
            total++; if (in_ready !== ~stall) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, ~stall); end
            clock_edge();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_waw();
        test_zero_nowrite();
        test_stall();
        test_flush_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
